// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert one parity bit (even or odd per PARITY_ODD) after the data bits.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk0,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q,    tx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q,   par_d;
`endif
  logic              bit_end_s;

  assign bit_end_s = (baud_q == BAUD_LAST);

  // Next-state logic; tx_d is the line level for the cycle after the edge, so tx stays registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (tx_valid) begin
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = parity_of(tx_data);
`endif
          state_d = S_START;
          tx_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          baud_d  = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end_s) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame immediately with the line idle high.
  always_ff @(posedge clk0 or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_ready = ~busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: a line monitor decodes frames and compares them with queued words.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB    = 4;
  localparam int DW     = 8;
  localparam int NBITS  = 1 + DW + P + 1;
  localparam int FRAME1 = NBITS * CPB;
  localparam int DW2    = 5;
  localparam int FRAME2 = (1 + DW2 + P + 2) * CPB;

  logic          clk0 = 1'b0;
  logic          reset_in = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx, busy, done;
  logic [DW2-1:0] tx_data2 = '0;
  logic          tx_valid2 = 1'b0;
  logic          tx_ready2, tx2, busy2, done2;

  uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .clk0(clk0), .reset_in(reset_in), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done));

  uart_tx_param #(.DATA_W(DW2), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
    .clk0(clk0), .reset_in(reset_in), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .done(done2));

  always #5 clk0 = ~clk0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  logic [DW-1:0] exp_q[$];
  logic          exp2_q[$];

  // Line monitor: samples tx every falling edge, rebuilds each frame and checks it against the queue.
  logic          in_frame = 1'b0;
  int            k = 0, cyc = 0, last_done_cyc = -100, gap_last = 0;
  logic          bits_r [NBITS];
  logic          hold_err, ready_err, done_err;
  always @(negedge clk0) begin
    int idx, off;
    logic [DW-1:0] w, rx;
    cyc++;
    if (!reset_in) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (done) check_val("spurious_done", done, 0);
        if (busy && !tx) begin
          in_frame = 1'b1; k = 0; gap_last = cyc - last_done_cyc;
          hold_err = 1'b0; ready_err = 1'b0; done_err = 1'b0;
        end
      end
      if (in_frame) begin
        k++;
        if (k <= FRAME1) begin
          idx = (k - 1) / CPB; off = (k - 1) % CPB;
          if (off == 0) bits_r[idx] = tx;
          else if (tx != bits_r[idx]) hold_err = 1'b1;
          if (tx_ready) ready_err = 1'b1;
          if (done) done_err = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            check_val("sb_empty", 0, 1);
            w = '0;
          end else begin
            w = exp_q.pop_front();
          end
          for (int i = 0; i < DW; i++) rx[i] = bits_r[1 + i];
          check_val("start_bit", bits_r[0], 0);
          check_val("data", rx, w);
          if (P == 1) check_val("parity_even", bits_r[1 + DW], ^w);
          check_val("stop_bit", bits_r[NBITS - 1], 1);
          check_val("bit_hold", hold_err, 0);
          check_val("ready_in_frame", ready_err, 0);
          check_val("done_in_frame", done_err, 0);
          check_val("done_at_end", done, 1);
          check_val("busy_at_end", busy, 0);
          check_val("ready_at_end", tx_ready, 1);
          check_val("tx_idle_at_end", tx, 1);
          last_done_cyc = cyc;
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] w);
    @(negedge clk0);
    tx_data = w; tx_valid = 1'b1;
    exp_q.push_back(w);
    for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk0);
    if (!tx_ready) check_val("accept_timeout", 0, 1);
    @(posedge clk0); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk0); #1;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    if (n >= 200) check_val("idle_timeout", n, 0);
  endtask

  task automatic send2(input logic [DW2-1:0] w);
    int mism;
    logic e;
    @(negedge clk0);
    tx_data2 = w; tx_valid2 = 1'b1;
    for (int i = 0; i < CPB; i++) exp2_q.push_back(1'b0);
    for (int b = 0; b < DW2; b++)
      for (int i = 0; i < CPB; i++) exp2_q.push_back(w[b]);
    if (P == 1) for (int i = 0; i < CPB; i++) exp2_q.push_back(~(^w));
    for (int i = 0; i < 2 * CPB; i++) exp2_q.push_back(1'b1);
    @(posedge clk0); #1;
    tx_valid2 = 1'b0;
    mism = 0;
    for (int i = 0; i < FRAME2; i++) begin
      @(negedge clk0);
      e = exp2_q.pop_front();
      if (tx2 !== e || done2 !== 1'b0 || busy2 !== 1'b1) mism++;
    end
    check_val("dut2_frame_mismatches", mism, 0);
    @(negedge clk0);
    check_val("dut2_done", done2, 1);
    check_val("dut2_tx_idle", tx2, 1);
    check_val("dut2_busy", busy2, 0);
    @(negedge clk0);
    check_val("dut2_done_one_cycle", done2, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk0);
    #1;
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", tx_ready, 1);
    @(negedge clk0);
    reset_in = 1'b1;

    send(8'hA5); wait_idle();
    send(8'h07); wait_idle();

    // Back-to-back words with tx_valid held high.
    @(negedge clk0);
    tx_data = 8'h00; tx_valid = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge clk0); #1;
    tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    @(negedge clk0);
    for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk0);
    @(posedge clk0); #1;
    tx_valid = 1'b0;
    @(negedge clk0); #1;
    check_val("b2b_busy_after_done", busy, 1);
    check_val("b2b_idle_gap", gap_last, 1);
    wait_idle();

    // Input changes during a frame must not disturb it.
    send(8'h3C);
    repeat (10) @(negedge clk0);
    tx_data = 8'hC3; tx_valid = 1'b1;
    repeat (5) @(negedge clk0);
    tx_valid = 1'b0;
    wait_idle();

    // Abort at cycle 13, then accept on the first edge after release.
    send(8'h5A);
    repeat (12) @(posedge clk0);
    #2 reset_in = 1'b0;
    #1;
    check_val("abort_tx", tx, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_ready", tx_ready, 1);
    check_val("abort_done", done, 0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk0);
    tx_data = 8'h96; tx_valid = 1'b1; reset_in = 1'b1;
    exp_q.push_back(8'h96);
    @(posedge clk0); #1;
    tx_valid = 1'b0;
    check_val("accept_after_reset_busy", busy, 1);
    check_val("accept_after_reset_tx", tx, 0);
    wait_idle();

    send2(5'h1F);
    send2(5'h07);

    repeat (3) @(negedge clk0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk0 cycles per serial bit; legal values are 2 or more.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning number of stop bits; legal values are 1 or 2.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity; it has effect only with UART_TX_PARITY_EN.
REQ-005 The block SHALL have port clk0, input, width 1: the single clock, rising edge.
REQ-006 The block SHALL have port reset_in, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port tx_data, input, width DATA_W: word to transmit.
REQ-008 The block SHALL have port tx_valid, input, width 1: tx_data is valid.
REQ-009 The block SHALL have port tx_ready, output, width 1: the block can accept a word.
REQ-010 The block SHALL have port tx, output, width 1: serial line, idle high.
REQ-011 The block SHALL have port busy, output, width 1: a frame is in progress.
REQ-012 The block SHALL have port done, output, width 1: one-cycle pulse when a frame completes.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY exists only with UART_TX_PARITY_EN.
REQ-014 tx_ready SHALL be 1 only in IDLE; a word is accepted on any rising edge where tx_valid=1 and tx_ready=1.
REQ-015 On acceptance, tx_data SHALL be latched into a shift register, and the FSM SHALL move from IDLE to START.
REQ-016 tx SHALL be registered and SHALL drive 0 (start bit) from the first cycle after acceptance.
REQ-017 Every serial bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1; the counter clears on each state change.
REQ-018 DATA SHALL send DATA_W bits, LSB first, using a bit index running 0..DATA_W-1; the FSM leaves DATA after index DATA_W-1.
REQ-019 PARITY SHALL send the XOR of the latched bits when PARITY_ODD=0, and the inverted XOR when PARITY_ODD=1.
REQ-020 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles and then return to IDLE.
REQ-021 done SHALL be 1 for exactly the first IDLE cycle after STOP, and 0 at all other times.
REQ-022 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-023 Frame length from acceptance edge to return to IDLE SHALL be (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
REQ-024 With tx_valid held high, the next word SHALL be accepted in the done cycle, so consecutive frames are separated by exactly one idle-high cycle.
REQ-025 Changes on tx_data or tx_valid while busy=1 SHALL be ignored and SHALL NOT alter the frame in flight.
REQ-026 In IDLE, tx SHALL be 1.

Reset
REQ-027 While reset_in=0, outputs SHALL be tx=1, busy=0, done=0 and tx_ready=1; the FSM SHALL be in IDLE, and the counters and shift register SHALL be 0.
REQ-028 Assertion of reset_in mid-frame SHALL abort the frame immediately (asynchronously), with tx=1 and no done pulse.
REQ-029 After reset_in deasserts, a word SHALL be acceptable on the first rising edge.

Configuration
REQ-030 Macro UART_TX_PARITY_EN SHALL compile in the PARITY state and one parity bit between the last data bit and the first stop bit.
REQ-031 Without UART_TX_PARITY_EN, the block SHALL send no parity bit, DATA SHALL go directly to STOP, and PARITY_ODD SHALL be ignored.

Verification
REQ-032 Scenario: no macro, DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, send 0xA5 -> tx samples 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses at cycle 40 after acceptance.
REQ-033 Scenario: macro, PARITY_ODD=0, send 0x07 -> parity bit=1; with PARITY_ODD=1, send 0x07 -> parity bit=0; frame is 44 cycles.
REQ-034 Scenario: tx_valid held high, words 0x00 then 0xFF -> two frames with exactly one tx=1 idle cycle between them; tx_ready is high only in the done cycles.
REQ-035 Scenario: STOP_BITS=2, DATA_W=5, send 0x1F -> stop high for 8 cycles; frame is 32 cycles.
REQ-036 Scenario: assert reset_in at cycle 13 of a frame -> tx=1, busy=0, tx_ready=1 in the same cycle, no done pulse; a new word is accepted on the first edge after release.
REQ-037 Scenario: change tx_data from 0x3C to 0xC3 while busy=1 -> the transmitted bits still encode 0x3C.
